fir_filter_gen: RTL and testbench

- Parametrised block FIR engine: successor to the fixed 8×8 FIR core.
- Each accepted block of LANES new input samples produces LANES filtered outputs over a TAPS-long, runtime-loadable coefficient set.
- Output is rounded, shifted and saturated.
- Sits between the sample deserialiser and the output formatter; history persists across blocks, so consecutive blocks form one continuous stream.

---
 rtl/fir_pkg.sv | 51 +++++
 rtl/fir_mac_lane.sv | 77 +++++++
 rtl/fir_filter_gen.sv | 187 ++++++++++++++++++
 tb/tb_fir_filter_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the block FIR engine:
//   fir_state_e : control FSM states (IDLE, RUN, FLUSH, OUT)
//   acc_width() : full-precision accumulator width for a given configuration
//   round_sat() : round-half-up, arithmetic shift and saturate an accumulator
//                 value to the output width
// No ports (package).
// ---------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

    // round_sat works on a fixed wide container so one function serves every
    // lane configuration; callers sign-extend in and truncate out.
    localparam int MAX_ACC_W = 128;
    localparam int MAX_OUT_W = 64;

    function automatic int acc_width(input int sample_w, input int coef_w, input int taps);
        return sample_w + coef_w + $clog2(taps);
    endfunction

    function automatic logic signed [MAX_OUT_W-1:0] round_sat(
        input logic signed [MAX_ACC_W-1:0] acc,
        input int                          shift,
        input int                          out_w
    );
        logic signed [MAX_ACC_W-1:0] v;
        logic signed [MAX_ACC_W-1:0] max_v;
        logic signed [MAX_ACC_W-1:0] min_v;
        v = acc;
        if (shift > 0) begin
            v = v + (128'sd1 <<< (shift - 1));
        end
        v     = v >>> shift;
        max_v = (128'sd1 <<< (out_w - 1)) - 128'sd1;
        min_v = -max_v - 128'sd1;
        if (v > max_v) begin
            return max_v[MAX_OUT_W-1:0];
        end else if (v < min_v) begin
            return min_v[MAX_OUT_W-1:0];
        end
        return v[MAX_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// ---------------------------------------------------------------------------
// fir_mac_lane
// One output lane of the block FIR: registered multiply, full-precision
// accumulate and a rounded/saturated output register.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   mul_en    in   register sample*coef this cycle (one tap)
//   acc_clr   in   clear accumulator (block start)
//   out_en    in   load output register from the accumulator
//   sample_in in   signed sample selected by the top level for this tap
//   coef_in   in   signed coefficient for this tap
//   y_out     out  rounded, shifted, saturated lane result (held)
// ---------------------------------------------------------------------------
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int ACC_WIDTH    = 37,
    parameter int OUT_WIDTH    = 32,
    parameter int OUT_SHIFT    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mul_en,
    input  logic                          acc_clr,
    input  logic                          out_en,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic signed [COEF_WIDTH-1:0]   coef_in,
    output logic signed [OUT_WIDTH-1:0]    y_out
);

    localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;

    logic signed [PROD_W-1:0]    prod_p1_d, prod_p1_q;
    logic                        vld_p1_d,  vld_p1_q;
    logic signed [ACC_WIDTH-1:0] acc_p2_d,  acc_p2_q;
    logic signed [OUT_WIDTH-1:0] out_p3_d,  out_p3_q;

    always_comb begin
        // Stage 1: product register
        prod_p1_d = mul_en ? (PROD_W'(sample_in) * PROD_W'(coef_in)) : prod_p1_q;
        vld_p1_d  = mul_en;

        // Stage 2: accumulate; clear wins since a new block starts from zero
        acc_p2_d = acc_p2_q;
        if (acc_clr) begin
            acc_p2_d = '0;
        end else if (vld_p1_q) begin
            acc_p2_d = acc_p2_q + ACC_WIDTH'(prod_p1_q);
        end

        // Stage 3: rounded/saturated output, held until the next block ends
        out_p3_d = out_p3_q;
        if (out_en) begin
            out_p3_d = OUT_WIDTH'(round_sat(MAX_ACC_W'(acc_p2_q), OUT_SHIFT, OUT_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            acc_p2_q  <= '0;
            out_p3_q  <= '0;
        end else begin
            prod_p1_q <= prod_p1_d;
            vld_p1_q  <= vld_p1_d;
            acc_p2_q  <= acc_p2_d;
            out_p3_q  <= out_p3_d;
        end
    end

    assign y_out = out_p3_q;

endmodule

// File: rtl/fir_filter_gen.sv
// ---------------------------------------------------------------------------
// fir_filter_gen
// Block FIR engine: each accepted block of LANES samples yields LANES outputs
// of a TAPS-long FIR with runtime-loadable coefficients. One tap per cycle is
// applied to all lanes in parallel; history persists across blocks.
// Ports:
//   clkIn        in   clock (rising edge)
//   resetIn      in   synchronous active-high reset
//   startIn      in   request one block (ignored while busy)
//   dataIn       in   LANES samples, lane 0 (oldest) in the low bits
//   clearHistIn  in   zero the sample history (ignored while busy)
//   coefWrIn     in   coefficient write strobe
//   coefAddrIn   in   coefficient tap index
//   coefDataIn   in   signed coefficient value
//   busyOut      out  block in progress
//   doneOut      out  one-cycle pulse, dataOut just updated
//   coefDropOut  out  one-cycle pulse, a write was rejected while busy
//   dataOut      out  LANES results, lane k = y[n+k]
// ---------------------------------------------------------------------------
module fir_filter_gen
    import fir_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int TAPS         = 32,
    parameter int LANES        = 4,
    parameter int OUT_WIDTH    = 32,
    parameter int OUT_SHIFT    = 0
) (
    input  logic                          clkIn,
    input  logic                          resetIn,
    input  logic                          startIn,
    input  logic [SAMPLE_WIDTH*LANES-1:0] dataIn,
    input  logic                          clearHistIn,
    input  logic                          coefWrIn,
    input  logic [$clog2(TAPS)-1:0]       coefAddrIn,
    input  logic [COEF_WIDTH-1:0]         coefDataIn,
    output logic                          busyOut,
    output logic                          doneOut,
    output logic                          coefDropOut,
    output logic [OUT_WIDTH*LANES-1:0]    dataOut
);

    localparam int ACC_WIDTH = acc_width(SAMPLE_WIDTH, COEF_WIDTH, TAPS);
    localparam int TAP_W     = $clog2(TAPS);
    localparam int HLEN      = TAPS - 1 + LANES;
    localparam int HIST_IW   = $clog2(HLEN);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

    fir_state_e                    state_d, state_q;
    logic [TAP_W-1:0]              tap_d, tap_q;
    logic                          flush_d, flush_q;
    logic                          done_d, done_q;
    logic                          drop_d, drop_q;
    logic signed [SAMPLE_WIDTH-1:0] hist_d [HLEN];
    logic signed [SAMPLE_WIDTH-1:0] hist_q [HLEN];
    logic signed [COEF_WIDTH-1:0]   coef_d [TAPS];
    logic signed [COEF_WIDTH-1:0]   coef_q [TAPS];

    logic busy;
    logic accept;
    logic mul_en;
    logic out_en;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        flush_d = flush_q;
        hist_d  = hist_q;
        coef_d  = coef_q;

        // OUT is the doneOut cycle; it accepts a new block like IDLE does.
        busy   = (state_q == RUN) || (state_q == FLUSH);
        accept = startIn && !busy;
        mul_en = (state_q == RUN);
        out_en = (state_q == FLUSH) && flush_q;
        done_d = out_en;
        drop_d = coefWrIn && busy;

        case (state_q)
            IDLE, OUT: begin
                if (accept) begin
                    state_d = RUN;
                    tap_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (tap_q == TAP_LAST) begin
                    state_d = FLUSH;
                    flush_d = 1'b0;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            FLUSH: begin
                if (flush_q) begin
                    state_d = OUT;
                end else begin
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // History: clear first, then shift in the new block on top of it.
        if (!busy) begin
            if (clearHistIn) begin
                for (int i = 0; i < HLEN; i++) begin
                    hist_d[i] = '0;
                end
            end
            if (accept) begin
                for (int i = 0; i < TAPS - 1; i++) begin
                    hist_d[i] = hist_d[i + LANES];
                end
                for (int k = 0; k < LANES; k++) begin
                    hist_d[TAPS - 1 + k] = dataIn[SAMPLE_WIDTH*k +: SAMPLE_WIDTH];
                end
            end
        end

        // Commits at the same edge as a start, so that block sees the new value.
        if (coefWrIn && !busy && (32'(coefAddrIn) < TAPS)) begin
            coef_d[coefAddrIn] = coefDataIn;
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q <= IDLE;
            tap_q   <= '0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < HLEN; i++) begin
                hist_q[i] <= '0;
            end
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            flush_q <= flush_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            hist_q  <= hist_d;
            coef_q  <= coef_d;
        end
    end

    // Lane k at tap t needs x[n+k-t]; the newest sample of lane k sits at
    // history index TAPS-1+k, so walking t back from there never underflows.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [HIST_IW-1:0] NEWEST = HIST_IW'(TAPS - 1 + k);
        logic signed [SAMPLE_WIDTH-1:0] sample;
        logic signed [OUT_WIDTH-1:0]    y;

        assign sample = hist_q[NEWEST - HIST_IW'(tap_q)];

        fir_mac_lane #(
            .SAMPLE_WIDTH(SAMPLE_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .OUT_SHIFT   (OUT_SHIFT)
        ) u_lane (
            .clk      (clkIn),
            .rst      (resetIn),
            .mul_en   (mul_en),
            .acc_clr  (accept),
            .out_en   (out_en),
            .sample_in(sample),
            .coef_in  (coef_q[tap_q]),
            .y_out    (y)
        );

        assign dataOut[OUT_WIDTH*k +: OUT_WIDTH] = y;
    end

    assign busyOut     = busy;
    assign doneOut     = done_q;
    assign coefDropOut = drop_q;

endmodule

// File: tb/tb_fir_filter_gen.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_gen
// Drives two engines (OUT_SHIFT 0 and 4) with identical stimulus. A direct
// convolution model of the sample stream produces expected blocks that are
// queued at start and compared when doneOut pulses.
// ---------------------------------------------------------------------------
module tb_fir_filter_gen;

    localparam int SW    = 16;
    localparam int CW    = 16;
    localparam int TAPS  = 32;
    localparam int LANES = 4;
    localparam int OW    = 32;

    logic              clk = 1'b0;
    logic              resetIn = 1'b1;
    logic              startIn = 1'b0;
    logic [SW*LANES-1:0] dataIn = '0;
    logic              clearHistIn = 1'b0;
    logic              coefWrIn = 1'b0;
    logic [4:0]        coefAddrIn = '0;
    logic [CW-1:0]     coefDataIn = '0;

    logic              busyOut, doneOut, coefDropOut;
    logic [OW*LANES-1:0] dataOut;
    logic              busy_r, done_r, drop_r;
    logic [OW*LANES-1:0] data_r;

    int n_chk  = 0;
    int n_fail = 0;

    int   m_coef [TAPS];
    int   m_x [$];
    logic [127:0] exp0_q [$];
    logic [127:0] exp4_q [$];

    always #5 clk = ~clk;

    fir_filter_gen #(.SAMPLE_WIDTH(SW), .COEF_WIDTH(CW), .TAPS(TAPS), .LANES(LANES),
                     .OUT_WIDTH(OW), .OUT_SHIFT(0)) dut (
        .clkIn(clk), .resetIn(resetIn), .startIn(startIn), .dataIn(dataIn),
        .clearHistIn(clearHistIn), .coefWrIn(coefWrIn), .coefAddrIn(coefAddrIn),
        .coefDataIn(coefDataIn), .busyOut(busyOut), .doneOut(doneOut),
        .coefDropOut(coefDropOut), .dataOut(dataOut)
    );

    fir_filter_gen #(.SAMPLE_WIDTH(SW), .COEF_WIDTH(CW), .TAPS(TAPS), .LANES(LANES),
                     .OUT_WIDTH(OW), .OUT_SHIFT(4)) dut_r (
        .clkIn(clk), .resetIn(resetIn), .startIn(startIn), .dataIn(dataIn),
        .clearHistIn(clearHistIn), .coefWrIn(coefWrIn), .coefAddrIn(coefAddrIn),
        .coefDataIn(coefDataIn), .busyOut(busy_r), .doneOut(done_r),
        .coefDropOut(drop_r), .dataOut(data_r)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [127:0] pack_out(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [31:0] rnd_sat(input longint a, input int sh);
        longint v;
        v = a;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > longint'(32'sh7fffffff)) return 32'h7fffffff;
        if (v < -longint'(64'd2147483648)) return 32'h80000000;
        return v[31:0];
    endfunction

    // Direct convolution over the model stream for the newest LANES outputs.
    function automatic logic [127:0] model_block(input int sh);
        logic [127:0] r;
        longint acc;
        int m;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            m   = m_x.size() - LANES + k;
            acc = 0;
            for (int t = 0; t < TAPS; t++) begin
                if (m - t >= 0) acc += longint'(m_coef[t]) * longint'(m_x[m - t]);
            end
            r[32*k +: 32] = rnd_sat(acc, sh);
        end
        return r;
    endfunction

    task automatic model_push(input logic [63:0] d, input bit clr);
        logic signed [15:0] s;
        if (clr) m_x.delete();
        for (int k = 0; k < LANES; k++) begin
            s = d[16*k +: 16];
            m_x.push_back(int'(s));
        end
        exp0_q.push_back(model_block(0));
        exp4_q.push_back(model_block(4));
    endtask

    task automatic wr_coef(input int a, input int v);
        coefWrIn   = 1'b1;
        coefAddrIn = a[4:0];
        coefDataIn = v[15:0];
        m_coef[a]  = int'($signed(v[15:0]));
        step;
        coefWrIn   = 1'b0;
    endtask

    // Called at a negedge with the engine idle; returns at the negedge after
    // the accepting edge.
    task automatic start_blk(input logic [63:0] d, input bit clr, input bit wr,
                             input int wa, input int wv);
        startIn     = 1'b1;
        dataIn      = d;
        clearHistIn = clr;
        coefWrIn    = wr;
        coefAddrIn  = wa[4:0];
        coefDataIn  = wv[15:0];
        if (wr) m_coef[wa] = int'($signed(wv[15:0]));
        model_push(d, clr);
        step;
        startIn     = 1'b0;
        clearHistIn = 1'b0;
        coefWrIn    = 1'b0;
        chk("busy_after_start", busyOut, 1'b1);
    endtask

    task automatic cmp_out(input string tag);
        logic [127:0] e0, e4;
        e0 = (exp0_q.size() > 0) ? exp0_q.pop_front() : 'x;
        e4 = (exp4_q.size() > 0) ? exp4_q.pop_front() : 'x;
        chk({tag, "_data"}, dataOut, e0);
        chk({tag, "_data_r"}, data_r, e4);
    endtask

    task automatic wait_done(input string tag, input int already);
        int  cnt;
        bit  seen;
        cnt  = already;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            step;
            cnt++;
            if (doneOut) seen = 1'b1;
        end
        chk({tag, "_latency"}, cnt, TAPS + 2);
        chk({tag, "_busy_at_done"}, busyOut, 1'b0);
        chk({tag, "_done_r"}, done_r, 1'b1);
        cmp_out(tag);
        step;
        chk({tag, "_done_pulse"}, doneOut, 1'b0);
    endtask

    initial begin
        int cyc, last, ndone, extra;
        for (int t = 0; t < TAPS; t++) m_coef[t] = 0;

        // Reset state
        repeat (3) step;
        resetIn = 1'b0;
        chk("rst_busy", busyOut, 1'b0);
        chk("rst_done", doneOut, 1'b0);
        chk("rst_drop", coefDropOut, 1'b0);
        chk("rst_data", dataOut, '0);
        step;

        // Identity filter
        wr_coef(0, 1);
        start_blk(pack4(1, 2, 3, 4), 1'b1, 1'b0, 0, 0);
        wait_done("identity", 0);
        chk("identity_direct", dataOut, pack_out(1, 2, 3, 4));

        // Rounding on the shifted engine
        start_blk(pack4(8, -8, 7, 24), 1'b1, 1'b0, 0, 0);
        wait_done("round", 0);
        chk("round_direct", data_r, pack_out(1, 0, 0, 2));

        // Impulse response across two blocks
        for (int t = 0; t < TAPS; t++) wr_coef(t, t + 1);
        start_blk(pack4(1, 0, 0, 0), 1'b1, 1'b0, 0, 0);
        wait_done("impulse_a", 0);
        chk("impulse_a_direct", dataOut, pack_out(1, 2, 3, 4));
        start_blk(pack4(0, 0, 0, 0), 1'b0, 1'b0, 0, 0);
        wait_done("impulse_b", 0);
        chk("impulse_b_direct", dataOut, pack_out(5, 6, 7, 8));

        // Coefficient write while busy is dropped
        start_blk(pack4(1, 0, 0, 0), 1'b1, 1'b0, 0, 0);
        repeat (3) step;
        coefWrIn = 1'b1; coefAddrIn = 5'd0; coefDataIn = 16'd5;
        step;
        coefWrIn = 1'b0;
        chk("drop_pulse", coefDropOut, 1'b1);
        step;
        chk("drop_once", coefDropOut, 1'b0);
        wait_done("drop_blk", 5);
        start_blk(pack4(1, 0, 0, 0), 1'b1, 1'b0, 0, 0);
        wait_done("drop_next", 0);
        chk("drop_old_coef", dataOut, pack_out(1, 2, 3, 4));

        // startIn held high: one block per TAPS+3 cycles
        startIn = 1'b1;
        dataIn  = pack4(1, 1, 1, 1);
        model_push(pack4(1, 1, 1, 1), 1'b0);
        cyc = 0; last = 0; ndone = 0;
        while (cyc < 4 * (TAPS + 3) && ndone < 3) begin
            step;
            cyc++;
            if (doneOut) begin
                ndone++;
                cmp_out("hold");
                if (ndone > 1) chk("hold_gap", cyc - last, TAPS + 3);
                last = cyc;
                if (ndone < 3) model_push(pack4(1, 1, 1, 1), 1'b0);
                else startIn = 1'b0;
            end
        end
        startIn = 1'b0;
        chk("hold_ndone", ndone, 3);
        extra = 0;
        for (int i = 0; i < TAPS + 6; i++) begin
            step;
            if (doneOut) extra++;
        end
        chk("hold_extra", extra, 0);

        // Saturation, both directions
        for (int t = 0; t < TAPS; t++) wr_coef(t, -32768);
        for (int b = 0; b < 9; b++) begin
            start_blk(pack4(-32768, -32768, -32768, -32768), (b == 0), 1'b0, 0, 0);
            wait_done("sat_fill", 0);
        end
        chk("sat_pos", dataOut, {4{32'h7fffffff}});
        for (int t = 0; t < TAPS; t++) wr_coef(t, 32767);
        start_blk(pack4(-32768, -32768, -32768, -32768), 1'b0, 1'b0, 0, 0);
        wait_done("sat_neg_blk", 0);
        chk("sat_neg", dataOut, {4{32'h80000000}});

        // Reset during RUN at tap 10
        start_blk(pack4(3, 3, 3, 3), 1'b0, 1'b0, 0, 0);
        repeat (10) step;
        resetIn = 1'b1;
        step;
        resetIn = 1'b0;
        chk("midrst_busy", busyOut, 1'b0);
        chk("midrst_done", doneOut, 1'b0);
        chk("midrst_data", dataOut, '0);
        chk("midrst_data_r", data_r, '0);
        exp0_q.delete();
        exp4_q.delete();
        m_x.delete();
        for (int t = 0; t < TAPS; t++) m_coef[t] = 0;
        start_blk(pack4(5, 6, 7, 8), 1'b0, 1'b0, 0, 0);
        wait_done("after_rst", 0);
        chk("after_rst_zero", dataOut, '0);

        // Coefficient write in the same cycle as start is used by that block
        start_blk(pack4(1, 2, 3, 4), 1'b1, 1'b1, 0, 3);
        wait_done("wr_start", 0);
        chk("wr_start_direct", dataOut, pack_out(3, 6, 9, 12));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
